// File: rtl/sequence_framer_pkg.sv
// Shared constants, FSM state type and word-count helper for the sequence framer.
package sequence_framer_pkg;

  localparam int NUM_STREAMS       = 32;
  localparam int MAX_PAYLOAD_BYTES = 37;
  localparam int HDR_BYTES         = 8;
  localparam int WORD_BYTES        = 4;
  localparam int STREAM_AW         = $clog2(NUM_STREAMS);
  localparam int MAX_WORDS         = (MAX_PAYLOAD_BYTES + WORD_BYTES - 1) / WORD_BYTES;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_HDR  = 2'd1,
    SEND_SEQ  = 2'd2,
    SEND_DATA = 2'd3
  } state_t;

  // Number of 32-bit data words needed for n payload bytes.
  function automatic logic [3:0] num_words(input logic [5:0] n);
    logic [6:0] w_sum;
    w_sum = 7'(n) + 7'd3;
    return w_sum[5:2];
  endfunction

endpackage

// File: rtl/sequence_framer_seq_table.sv
// Per-stream 32-bit sequence counters: one async read port, one sync write port, async clear.
module seq_table
  import sequence_framer_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [STREAM_AW-1:0] i_rd_addr,
  output logic [31:0]          o_rd_data,
  input  logic                 i_wr_en,
  input  logic [STREAM_AW-1:0] i_wr_addr,
  input  logic [31:0]          i_wr_data
);

  logic [31:0] r_mem [NUM_STREAMS];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_STREAMS; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sequence_framer.sv
// Frames a payload as header word, sequence word and byte-packed data words,
// with a per-stream sequence counter held in seq_table.
module sequence_framer
  import sequence_framer_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [0:295]  payloadIn,
  input  logic [5:0]    payloadIn_bytes,
  input  logic [15:0]   payloadIn_stream,
  input  logic          payloadIn_val,
  output logic          payloadIn_ready,
  output logic [31:0]   dataOut,
  output logic          dataOut_val,
  input  logic          dataOut_ready,
  output logic          dataOut_last,
  output logic          lengthError
);

  localparam int PAD_BITS = MAX_WORDS * WORD_BYTES * 8;

  state_t                 r_state;
  logic [3:0]             r_widx;
  logic [0:PAD_BITS-1]    r_payload;
  logic [5:0]             r_bytes;
  logic [STREAM_AW-1:0]   r_stream_idx;
  logic [31:0]            r_seq;

  logic                   w_accept;
  logic                   w_len_ok;
  logic [31:0]            w_rd_data;
  logic                   w_tbl_we;
  logic [3:0]             w_nwords;
  logic [3:0]             w_word_idx;
  logic [31:0]            w_word;
  logic                   w_word_last;

  assign payloadIn_ready = (r_state == IDLE);
  assign w_accept        = payloadIn_val && payloadIn_ready;
  assign w_len_ok        = (payloadIn_bytes != 6'd0) &&
                           (payloadIn_bytes <= 6'(MAX_PAYLOAD_BYTES));
  assign w_nwords        = num_words(r_bytes);
  // The counter write-back happens while the header is on the bus; the next read is at least three cycles away.
  assign w_tbl_we        = (r_state == SEND_HDR);

  seq_table u_table (
    .i_clk     (clk),
    .i_rst     (reset),
    .i_rd_addr (payloadIn_stream[STREAM_AW-1:0]),
    .o_rd_data (w_rd_data),
    .i_wr_en   (w_tbl_we),
    .i_wr_addr (r_stream_idx),
    .i_wr_data (r_seq)
  );

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_payload    <= {payloadIn, 24'h0};
      r_bytes      <= payloadIn_bytes;
      r_stream_idx <= payloadIn_stream[STREAM_AW-1:0];
      r_seq        <= w_rd_data + 32'd1;
    end
  end

  // Next data word to present: word 0 when leaving SEND_SEQ, else the one after the current word.
  always_comb begin
    w_word_idx = (r_state == SEND_SEQ) ? 4'd0 : r_widx + 4'd1;
    w_word     = '0;
    for (int l = 0; l < WORD_BYTES; l++) begin
      logic [5:0] b;
      b = {w_word_idx, 2'b00} + 6'(l);
      if ((b < r_bytes) && (b < 6'(MAX_WORDS * WORD_BYTES)))
        w_word[31-8*l -: 8] = r_payload[8*b +: 8];
    end
    w_word_last = (w_word_idx == w_nwords - 4'd1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_widx       <= '0;
      dataOut      <= '0;
      dataOut_val  <= 1'b0;
      dataOut_last <= 1'b0;
      lengthError  <= 1'b0;
    end else begin
      lengthError <= 1'b0;
      case (r_state)
        IDLE: begin
          if (payloadIn_val) begin
            if (w_len_ok) begin
              r_state      <= SEND_HDR;
              dataOut      <= {16'(payloadIn_bytes) + 16'(HDR_BYTES), payloadIn_stream};
              dataOut_val  <= 1'b1;
              dataOut_last <= 1'b0;
            end else begin
              lengthError <= 1'b1;
            end
          end
        end
        SEND_HDR: begin
          if (dataOut_ready) begin
            r_state <= SEND_SEQ;
            dataOut <= r_seq;
          end
        end
        SEND_SEQ: begin
          if (dataOut_ready) begin
            r_state      <= SEND_DATA;
            r_widx       <= '0;
            dataOut      <= w_word;
            dataOut_last <= w_word_last;
          end
        end
        SEND_DATA: begin
          if (dataOut_ready) begin
            if (dataOut_last) begin
              r_state      <= IDLE;
              dataOut      <= '0;
              dataOut_val  <= 1'b0;
              dataOut_last <= 1'b0;
            end else begin
              r_widx       <= r_widx + 4'd1;
              dataOut      <= w_word;
              dataOut_last <= w_word_last;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sequence_framer.md
SEQUENCE_FRAMER -- requirements
Module: sequence_framer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port payloadIn, input, [0:295], payload bytes; byte k = payloadIn[8k:8k+7].
REQ-004 SHALL have port payloadIn_bytes, input, 6, payload byte count N (valid range 1..37).
REQ-005 SHALL have port payloadIn_stream, input, 16, stream ID.
REQ-006 SHALL have port payloadIn_val, input, 1, payload offer valid.
REQ-007 SHALL have port payloadIn_ready, output, 1, framer accepts payload.
REQ-008 SHALL have port dataOut, output, 32, serialized word.
REQ-009 SHALL have port dataOut_val, output, 1, dataOut valid.
REQ-010 SHALL have port dataOut_ready, input, 1, downstream accepts word.
REQ-011 SHALL have port dataOut_last, output, 1, final word of packet; qualified by dataOut_val.
REQ-012 SHALL have port lengthError, output, 1, one-cycle pulse on dropped bad-length payload.

Function
REQ-013 SHALL use FSM states IDLE, SEND_HDR, SEND_SEQ, SEND_DATA; payloadIn_ready = (state==IDLE).
REQ-014 SHALL accept on payloadIn_val && payloadIn_ready; capture payload, N, stream into registers.
REQ-015 SHALL, on accept with 1<=N<=37: seq = table[stream[4:0]]+1 (mod 2^32), write seq back to table, go to SEND_HDR.
REQ-016 SHALL, on accept with N==0 or N>37: not touch table, stay IDLE, assert lengthError next cycle for exactly one cycle.
REQ-017 SHALL in SEND_HDR drive dataOut = {N+8 (16 bits), stream[15:0]}, dataOut_val=1, dataOut_last=0.
REQ-018 SHALL in SEND_SEQ drive dataOut = seq, dataOut_val=1, dataOut_last=0.
REQ-019 SHALL in SEND_DATA emit ceil(N/4) words; word w = {byte 4w, 4w+1, 4w+2, 4w+3}, byte 4w in dataOut[31:24].
REQ-020 SHALL zero byte lanes with index >= N in the final data word; assert dataOut_last only on that word.
REQ-021 SHALL advance one word per cycle where dataOut_val && dataOut_ready; hold dataOut/dataOut_last stable otherwise.
REQ-022 SHALL return to IDLE after the last-word handshake; first header valid one cycle after accept; one idle bubble between packets.
REQ-023 SHALL use 16-bit length arithmetic; header length field = N+8 (range 9..45).
REQ-024 SHALL index sequence table with stream[4:0] only; streams aliasing mod 32 share a counter.
REQ-025 SHALL wrap seq 0xFFFFFFFF -> 0x00000000 without error.
REQ-026 SHALL keep dataOut_val=0 and dataOut_last=0 in IDLE.

Reset
REQ-027 SHALL on reset assertion immediately force state IDLE, dataOut_val=0, dataOut_last=0, lengthError=0, payloadIn_ready=1 after release.
REQ-028 SHALL clear all 32 table entries to 0 so first packet per stream carries seq 1.
REQ-029 SHALL abandon any in-flight packet on reset mid-operation; no partial words after release.
REQ-030 SHALL reset dataOut to 0.

Structure
REQ-031 SHALL place in the shared parser package: NUM_STREAMS=32, MAX_PAYLOAD_BYTES=37, HDR_BYTES=8, WORD_BYTES=4, the FSM state enum.
REQ-032 SHALL contain one sub-module seq_table: 32x32 registers, one read port, one write port, async clear.
REQ-033 SHALL keep byte-lane masking and word select in the top module.

Verification
REQ-034 SHALL verify: after reset, N=37, stream=0x0003, all ready -> words 0x002D0003, 0x00000001, 9 full words, 10th word = byte36 in [31:24], zeros below, last=1.
REQ-035 SHALL verify: two N=4 packets on stream 5 -> seq 1 then 2; each packet 3 words; second header one cycle after IDLE.
REQ-036 SHALL verify: dataOut_ready low 5 cycles on SEQ word -> dataOut held at seq, no skipped/duplicated words.
REQ-037 SHALL verify: N=0 then N=40 -> two lengthError pulses, no dataOut_val, next valid packet on that stream uses seq 1.
REQ-038 SHALL verify: streams 0x0001 and 0x0021 alternately -> seq 1,2,3,4 (shared entry); table preset 0xFFFFFFFF -> seq 0.
REQ-039 SHALL verify: reset during SEND_DATA -> dataOut_val low same cycle; after release next packet starts with header.
